reg_wb_ctrl: RTL

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

---
 rtl/reg_wb_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - register-file write-back arbiter with a small load-result queue
//
// Merges ALU results and load results into a single register-file write port.
// ALU results always win. A load that cannot write in the cycle it arrives waits
// in a short circular queue. A younger ALU write to the same register removes
// any queued load that targets that register.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   alu_valid/wn/wd       ALU result (destination 0 is ignored)
//   ld_valid/wn/wd        load result (destination 0 is ignored)
//   ld_ready              queue has room; derived from the registered count only
//   RegWrite/WN/WD        registered register-file write port (WN/WD hold when idle)
//   q_count               registered number of queued loads
//   ld_drop               one-cycle pulse when a load arrives while ld_ready=0
module reg_wb_ctrl #(
   parameter int QDEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_wn,
   input  logic [31:0] alu_wd,
   input  logic        ld_valid,
   input  logic [4:0]  ld_wn,
   input  logic [31:0] ld_wd,
   output logic        ld_ready,
   output logic        RegWrite,
   output logic [4:0]  WN,
   output logic [31:0] WD,
   output logic [2:0]  q_count,
   output logic        ld_drop
);

   localparam int PW = $clog2(QDEPTH);

   logic [QDEPTH-1:0][4:0]  q_wn, n_wn;
   logic [QDEPTH-1:0][31:0] q_wd, n_wd;
   logic [QDEPTH-1:0]       q_v, n_v;
   logic [PW-1:0]           head, head_n, slot, tail_n;
   logic [2:0]              k;
   logic                    alu_issue, pop, ld_ok, bypass, push, drop;

   assign ld_ready = (q_count < 3'(QDEPTH));

   // Next queue state. Surviving entries are re-packed behind the new head, so
   // entries killed by an ALU write never leave a hole that a later pop would
   // have to spend a cycle skipping. The tail is always head + count (mod QDEPTH).
   always_comb begin
      alu_issue = alu_valid && (alu_wn != 5'd0);
      pop       = !alu_issue && (q_count != 3'd0);
      ld_ok     = ld_valid && (ld_wn != 5'd0) && ld_ready;
      bypass    = ld_ok && !alu_issue && (q_count == 3'd0);
      push      = ld_ok && !bypass && !(alu_issue && (ld_wn == alu_wn));
      drop      = ld_valid && (ld_wn != 5'd0) && !ld_ready;
      head_n    = pop ? head + PW'(1) : head;

      n_wn   = q_wn;
      n_wd   = q_wd;
      n_v    = '0;
      k      = 3'd0;
      slot   = '0;
      tail_n = '0;

      for (int i = 0; i < QDEPTH; i++) begin
         slot = head + PW'(i);
         if (q_v[slot] && !(pop && i == 0) && !(alu_issue && q_wn[slot] == alu_wn)) begin
            tail_n       = head_n + PW'(k);
            n_wn[tail_n] = q_wn[slot];
            n_wd[tail_n] = q_wd[slot];
            n_v[tail_n]  = 1'b1;
            k            = k + 3'd1;
         end
      end

      if (push) begin
         tail_n       = head_n + PW'(k);
         n_wn[tail_n] = ld_wn;
         n_wd[tail_n] = ld_wd;
         n_v[tail_n]  = 1'b1;
         k            = k + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWrite <= 1'b0;
         WN       <= 5'd0;
         WD       <= 32'd0;
         q_count  <= 3'd0;
         ld_drop  <= 1'b0;
         head     <= '0;
         q_v      <= '0;
         q_wn     <= '0;
         q_wd     <= '0;
      end else begin
         RegWrite <= alu_issue || pop || bypass;
         if (alu_issue) begin
            WN <= alu_wn;
            WD <= alu_wd;
         end else if (pop) begin
            WN <= q_wn[head];
            WD <= q_wd[head];
         end else if (bypass) begin
            WN <= ld_wn;
            WD <= ld_wd;
         end
         q_count <= k;
         ld_drop <= drop;
         head    <= head_n;
         q_v     <= n_v;
         q_wn    <= n_wn;
         q_wd    <= n_wd;
      end
   end

endmodule
